// File: rtl/robo_sequenciador.sv
// Command sequencer between the decision FSM and the actuators.
// Queues one-shot moves in a FIFO and plays each back as a fixed-length
// actuator pulse. Counts completed advances and halts after too many
// consecutive turns until software clears the trapped condition.
module robo_sequenciador #(
    parameter int unsigned T_AVANCAR  = 4,
    parameter int unsigned T_GIRAR    = 2,
    parameter int unsigned T_REMOVER  = 6,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_GIROS  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    input  logic        clear_trapped,
    output logic        motor_frente,
    output logic        motor_giro,
    output logic        garra,
    output logic        busy,
    output logic        done,
    output logic        trapped,
    output logic [15:0] passos
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned T_AG   = (T_AVANCAR > T_GIRAR) ? T_AVANCAR : T_GIRAR;
    localparam int unsigned T_MAX  = (T_AG > T_REMOVER) ? T_AG : T_REMOVER;
    localparam int unsigned TMR_W  = $clog2(T_MAX + 1);
    localparam int unsigned GIR_W  = $clog2(MAX_GIROS + 1);
    localparam int unsigned PAS_W  = 16;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_AVANCAR = 2'b01;
    localparam logic [1:0] OP_GIRAR   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_TRAPPED = 2'd2
    } state_t;

    // FIFO storage
    logic [1:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // FSM and output registers
    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic [1:0]       r_op;
    logic [GIR_W-1:0] r_giros;
    logic [PAS_W-1:0] r_passos;
    logic             r_frente;
    logic             r_giro;
    logic             r_garra;
    logic             r_busy;
    logic             r_done;
    logic             r_trapped;

    // Next-state values
    state_t           w_state_nxt;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [1:0]       w_op_nxt;
    logic [GIR_W-1:0] w_giros_nxt;
    logic [PAS_W-1:0] w_passos_nxt;
    logic             w_frente_nxt;
    logic             w_giro_nxt;
    logic             w_garra_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_trapped_nxt;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic [1:0]       w_head;

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_head    = r_mem[r_rd_ptr];
    assign cmd_ready = !w_full && !r_trapped;
    // NOPs complete the handshake but are never stored
    assign w_push    = cmd_valid && cmd_ready && (cmd_op != OP_NOP);

    // FIFO pointers and storage; a flush on trap entry overrides any push
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= OP_NOP;
            end
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= cmd_op;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_op      <= OP_NOP;
            r_giros   <= '0;
            r_passos  <= '0;
            r_frente  <= 1'b0;
            r_giro    <= 1'b0;
            r_garra   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_trapped <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_op      <= w_op_nxt;
            r_giros   <= w_giros_nxt;
            r_passos  <= w_passos_nxt;
            r_frente  <= w_frente_nxt;
            r_giro    <= w_giro_nxt;
            r_garra   <= w_garra_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_trapped <= w_trapped_nxt;
        end
    end

    // Next-state logic: dequeue, time the pulse, update counters, trap
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_op_nxt      = r_op;
        w_giros_nxt   = r_giros;
        w_passos_nxt  = r_passos;
        w_frente_nxt  = r_frente;
        w_giro_nxt    = r_giro;
        w_garra_nxt   = r_garra;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_trapped_nxt = r_trapped;
        w_pop         = 1'b0;
        w_flush       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_op_nxt    = w_head;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_EXEC;
                    unique case (w_head)
                        OP_AVANCAR: begin
                            w_timer_nxt  = TMR_W'(T_AVANCAR - 1);
                            w_frente_nxt = 1'b1;
                        end
                        OP_GIRAR: begin
                            w_timer_nxt = TMR_W'(T_GIRAR - 1);
                            w_giro_nxt  = 1'b1;
                        end
                        default: begin
                            w_timer_nxt = TMR_W'(T_REMOVER - 1);
                            w_garra_nxt = 1'b1;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end else begin
                    w_frente_nxt = 1'b0;
                    w_giro_nxt   = 1'b0;
                    w_garra_nxt  = 1'b0;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                    unique case (r_op)
                        OP_AVANCAR: begin
                            if (r_passos != {PAS_W{1'b1}}) begin
                                w_passos_nxt = r_passos + PAS_W'(1);
                            end
                            w_giros_nxt = '0;
                        end
                        OP_GIRAR: begin
                            if (r_giros == GIR_W'(MAX_GIROS - 1)) begin
                                w_giros_nxt   = GIR_W'(MAX_GIROS);
                                w_trapped_nxt = 1'b1;
                                w_flush       = 1'b1;
                                w_state_nxt   = ST_TRAPPED;
                            end else begin
                                w_giros_nxt = r_giros + GIR_W'(1);
                            end
                        end
                        default: begin
                            w_giros_nxt = '0;
                        end
                    endcase
                end
            end
            ST_TRAPPED: begin
                if (clear_trapped) begin
                    w_giros_nxt   = '0;
                    w_trapped_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign motor_frente = r_frente;
    assign motor_giro   = r_giro;
    assign garra        = r_garra;
    assign busy         = r_busy;
    assign done         = r_done;
    assign trapped      = r_trapped;
    assign passos       = r_passos;

endmodule

// File: tb/tb_robo_sequenciador.sv
// Bench for robo_sequenciador: directed scenarios plus random traffic,
// checked every cycle against a queue-based behavioural model.
module tb_robo_sequenciador;

    localparam int T_A   = 4;
    localparam int T_G   = 2;
    localparam int T_R   = 6;
    localparam int DEPTH = 4;
    localparam int MAXG  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic        cmd_ready;
    logic        clear_trapped = 1'b0;
    logic        motor_frente;
    logic        motor_giro;
    logic        garra;
    logic        busy;
    logic        done;
    logic        trapped;
    logic [15:0] passos;

    int n_cmp = 0;
    int n_err = 0;
    bit saw_block = 0;

    robo_sequenciador #(
        .T_AVANCAR (T_A),
        .T_GIRAR   (T_G),
        .T_REMOVER (T_R),
        .FIFO_DEPTH(DEPTH),
        .MAX_GIROS (MAXG)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_ready    (cmd_ready),
        .clear_trapped(clear_trapped),
        .motor_frente (motor_frente),
        .motor_giro   (motor_giro),
        .garra        (garra),
        .busy         (busy),
        .done         (done),
        .trapped      (trapped),
        .passos       (passos)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    int q[$];          // pending ops in arrival order
    int m_op = 0;      // op whose pulse is running, 0 = none
    int m_left = 0;    // pulse cycles left
    bit m_done = 0;
    bit m_trapped = 0;
    int m_turns = 0;
    int m_passos = 0;

    function automatic int pulse_len(input int op);
        if (op == 1) return T_A;
        if (op == 2) return T_G;
        return T_R;
    endfunction

    always @(posedge clock or posedge reset) begin : mdl
        bit acc;
        bit trap_now;
        if (reset) begin
            q.delete();
            m_op = 0; m_left = 0; m_done = 0;
            m_trapped = 0; m_turns = 0; m_passos = 0;
        end else begin
            acc = cmd_valid && (q.size() < DEPTH) && !m_trapped;
            trap_now = 0;
            m_done = 0;
            if (m_trapped) begin
                if (clear_trapped) begin
                    m_trapped = 0;
                    m_turns = 0;
                end
            end else if (m_op != 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    if (m_op == 1) begin
                        if (m_passos < 65535) m_passos++;
                        m_turns = 0;
                    end else if (m_op == 2) begin
                        m_turns++;
                        if (m_turns >= MAXG) begin
                            m_trapped = 1;
                            trap_now = 1;
                            q.delete();
                        end
                    end else begin
                        m_turns = 0;
                    end
                    m_op = 0;
                end
            end else if (q.size() > 0) begin
                m_op = q.pop_front();
                m_left = pulse_len(m_op);
            end
            if (acc && cmd_op != 2'b00 && !trap_now) q.push_back(int'(cmd_op));
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clock) begin : cmp
        logic [22:0] act;
        logic [22:0] exp;
        act = {motor_frente, motor_giro, garra, busy, done, trapped, cmd_ready, passos};
        exp = {m_op == 1, m_op == 2, m_op == 3, m_op != 0, m_done, m_trapped,
               (q.size() < DEPTH) && !m_trapped, 16'(m_passos)};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL cycle_model t=%0t frente/giro/garra/busy/done/trap/rdy got %b%b%b%b%b%b%b req %b%b%b%b%b%b%b passos got %0d req %0d",
                     $time, act[22], act[21], act[20], act[19], act[18], act[17], act[16],
                     exp[22], exp[21], exp[20], exp[19], exp[18], exp[17], exp[16],
                     act[15:0], exp[15:0]);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Offer one command at a negedge and hold it until the handshake completes
    task automatic send(input logic [1:0] op);
        int w = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        while (!cmd_ready && w < 200) begin
            saw_block = 1;
            @(negedge clock);
            w++;
        end
        check("send_accept", int'(cmd_ready), 1);
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int cnt_f;
        int cnt_d;
        int first_d;
        int w;
        bit saw_trap;

        tick(2);
        check("reset_outputs", int'({motor_frente, motor_giro, garra, busy, done, trapped}), 0);
        check("reset_ready", int'(cmd_ready), 1);
        check("reset_passos", int'(passos), 0);
        reset = 1'b0;
        tick(1);

        // Single advance: pulse of 4, done on the 5th cycle after acceptance
        send(2'b01);
        cnt_f = 0; cnt_d = 0; first_d = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (motor_frente) cnt_f++;
            if (done) begin cnt_d++; if (first_d == 0) first_d = k; end
        end
        check("adv_pulse_len", cnt_f, 4);
        check("adv_done_cnt", cnt_d, 1);
        check("adv_done_cycle", first_d, 5);
        check("adv_passos", int'(passos), 1);

        // girar, remover, avancar back to back
        send(2'b10); send(2'b11); send(2'b01);
        cnt_d = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (done) cnt_d++;
        end
        check("seq3_done_cnt", cnt_d, 3);
        check("seq3_passos", int'(passos), 2);

        // Overfill the FIFO with advances
        saw_block = 0;
        for (int k = 0; k < 6; k++) send(2'b01);
        check("fill_blocked", int'(saw_block), 1);
        tick(60);
        check("fill_passos", int'(passos), 8);

        // Four turns trap the robot; the queued advance is flushed
        for (int k = 0; k < 4; k++) send(2'b10);
        send(2'b01);
        w = 0;
        while (!trapped && w < 100) begin @(negedge clock); w++; end
        check("trap_set", int'(trapped), 1);
        check("trap_ready", int'(cmd_ready), 0);
        tick(3);
        check("trap_passos", int'(passos), 8);
        clear_trapped = 1'b1;
        tick(1);
        clear_trapped = 1'b0;
        check("trap_cleared", int'(trapped), 0);
        send(2'b01);
        tick(10);
        check("post_clear_passos", int'(passos), 9);

        // An advance between turns resets the consecutive count
        saw_trap = 0;
        send(2'b10); send(2'b10); send(2'b10); send(2'b01);
        send(2'b10); send(2'b10); send(2'b10);
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (trapped) saw_trap = 1;
        end
        check("no_trap", int'(saw_trap), 0);
        check("no_trap_passos", int'(passos), 10);

        // Reset during the third garra cycle
        send(2'b11);
        w = 0;
        while (!garra && w < 50) begin @(negedge clock); w++; end
        check("garra_started", int'(garra), 1);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_garra", int'(garra), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_passos", int'(passos), 0);
        check("rst_ready", int'(cmd_ready), 1);
        @(negedge clock);
        reset = 1'b0;
        tick(1);

        // NOP is accepted and never executes
        send(2'b00);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check("nop_idle", int'(busy), 0);
        end

        // Random traffic, biased toward turns to exercise trapping
        for (int k = 0; k < 3000; k++) begin
            cmd_valid     = ($urandom_range(0, 99) < 45);
            cmd_op        = ($urandom_range(0, 99) < 45) ? 2'b10 : 2'($urandom_range(0, 3));
            clear_trapped = ($urandom_range(0, 99) < 6);
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        clear_trapped = 1'b0;
        tick(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
